// File: rtl/idex_hazard.sv
// idex_hazard: ID/EX pipeline register with load-use hazard detection and flush bubbles.
// Latency: one cycle from ifid* to idex*; stall is combinational from the idex state and ifid inputs.
// Backpressure: stall holds PC and IF/ID for one cycle while a bubble enters EX; flush overrides stall.
//
// Ports:
//   clk, rst_n       - rising-edge clock, asynchronous active-low reset
//   ifid*            - decoded instruction from ID (register addresses, control bits, operands, imm, PC)
//   flush            - taken branch/jump resolved in EX; squash the instruction in ID
//   idex*            - registered ID/EX contents for the forwarding unit and ALU muxes
//   stall            - load-use stall request for this cycle
//   stallCnt         - saturating count of stall cycles (only when PERF_CNT_EN is defined)
//
// Build option: define PERF_CNT_EN to add the stallCnt port and its counter.

`ifndef RF_ADDR_WIDTH
`define RF_ADDR_WIDTH 5
`endif

module idex_hazard (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [`RF_ADDR_WIDTH-1:0] ifidRs1,
  input  logic [`RF_ADDR_WIDTH-1:0] ifidRs2,
  input  logic [`RF_ADDR_WIDTH-1:0] ifidRd,
  input  logic                      ifidValid,
  input  logic                      ifidRegWrite,
  input  logic                      ifidMemRead,
  input  logic                      ifidMemWrite,
  input  logic                      ifidMemToReg,
  input  logic                      ifidAluSrc,
  input  logic [3:0]                ifidAluOp,
  input  logic [31:0]               ifidRdata1,
  input  logic [31:0]               ifidRdata2,
  input  logic [31:0]               ifidImm,
  input  logic [31:0]               ifidPc,
  input  logic                      flush,
  output logic [`RF_ADDR_WIDTH-1:0] idexRs1,
  output logic [`RF_ADDR_WIDTH-1:0] idexRs2,
  output logic [`RF_ADDR_WIDTH-1:0] idexRd,
  output logic                      idexValid,
  output logic                      idexRegWrite,
  output logic                      idexMemRead,
  output logic                      idexMemWrite,
  output logic                      idexMemToReg,
  output logic                      idexAluSrc,
  output logic [3:0]                idexAluOp,
  output logic [31:0]               idexRdata1,
  output logic [31:0]               idexRdata2,
  output logic [31:0]               idexImm,
  output logic [31:0]               idexPc,
`ifdef PERF_CNT_EN
  output logic [31:0]               stallCnt,
`endif
  output logic                      stall
);

  localparam int AW = `RF_ADDR_WIDTH;

  logic [AW-1:0] rs1_q, rs1_d, rs2_q, rs2_d, rd_q, rd_d;
  logic          valid_q, valid_d, regwrite_q, regwrite_d, memread_q, memread_d;
  logic          memwrite_q, memwrite_d, memtoreg_q, memtoreg_d, alusrc_q, alusrc_d;
  logic [3:0]    aluop_q, aluop_d;
  logic [31:0]   rdata1_q, rdata1_d, rdata2_q, rdata2_d, imm_q, imm_d, pc_q, pc_d;

  logic store_data_only;
  logic hazard;
  logic bubble;

  // A store whose only dependence on the load is its write data is served by
  // the MEM-stage write-data forward, so it can proceed without a stall.
  assign store_data_only = ifidMemWrite && (rd_q == ifidRs2) && (rd_q != ifidRs1);

  assign hazard = valid_q && memread_q && (rd_q != '0) && ifidValid &&
                  ((rd_q == ifidRs1) || ((rd_q == ifidRs2) && !store_data_only));

  assign stall  = hazard && !flush;
  assign bubble = flush || stall;

  always_comb begin
    rs1_d      = rs1_q;
    rs2_d      = rs2_q;
    rd_d       = rd_q;
    valid_d    = valid_q;
    regwrite_d = regwrite_q;
    memread_d  = memread_q;
    memwrite_d = memwrite_q;
    memtoreg_d = memtoreg_q;
    alusrc_d   = alusrc_q;
    aluop_d    = aluop_q;
    rdata1_d   = rdata1_q;
    rdata2_d   = rdata2_q;
    imm_d      = imm_q;
    pc_d       = pc_q;
    if (bubble) begin
      // Bubble: kill every side effect and zero the source addresses so the
      // forwarding unit cannot match on a dead slot; datapath fields hold.
      valid_d    = 1'b0;
      regwrite_d = 1'b0;
      memread_d  = 1'b0;
      memwrite_d = 1'b0;
      memtoreg_d = 1'b0;
      rs1_d      = '0;
      rs2_d      = '0;
    end else begin
      rs1_d      = ifidRs1;
      rs2_d      = ifidRs2;
      rd_d       = ifidRd;
      // An invalid ID slot enters EX with its side-effect bits cleared.
      valid_d    = ifidValid;
      regwrite_d = ifidValid && ifidRegWrite;
      memread_d  = ifidValid && ifidMemRead;
      memwrite_d = ifidValid && ifidMemWrite;
      memtoreg_d = ifidValid && ifidMemToReg;
      alusrc_d   = ifidAluSrc;
      aluop_d    = ifidAluOp;
      rdata1_d   = ifidRdata1;
      rdata2_d   = ifidRdata2;
      imm_d      = ifidImm;
      pc_d       = ifidPc;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rs1_q      <= '0;
      rs2_q      <= '0;
      rd_q       <= '0;
      valid_q    <= 1'b0;
      regwrite_q <= 1'b0;
      memread_q  <= 1'b0;
      memwrite_q <= 1'b0;
      memtoreg_q <= 1'b0;
      alusrc_q   <= 1'b0;
      aluop_q    <= '0;
      rdata1_q   <= '0;
      rdata2_q   <= '0;
      imm_q      <= '0;
      pc_q       <= '0;
    end else begin
      rs1_q      <= rs1_d;
      rs2_q      <= rs2_d;
      rd_q       <= rd_d;
      valid_q    <= valid_d;
      regwrite_q <= regwrite_d;
      memread_q  <= memread_d;
      memwrite_q <= memwrite_d;
      memtoreg_q <= memtoreg_d;
      alusrc_q   <= alusrc_d;
      aluop_q    <= aluop_d;
      rdata1_q   <= rdata1_d;
      rdata2_q   <= rdata2_d;
      imm_q      <= imm_d;
      pc_q       <= pc_d;
    end
  end

  assign idexRs1      = rs1_q;
  assign idexRs2      = rs2_q;
  assign idexRd       = rd_q;
  assign idexValid    = valid_q;
  assign idexRegWrite = regwrite_q;
  assign idexMemRead  = memread_q;
  assign idexMemWrite = memwrite_q;
  assign idexMemToReg = memtoreg_q;
  assign idexAluSrc   = alusrc_q;
  assign idexAluOp    = aluop_q;
  assign idexRdata1   = rdata1_q;
  assign idexRdata2   = rdata2_q;
  assign idexImm      = imm_q;
  assign idexPc       = pc_q;

`ifdef PERF_CNT_EN
  logic [31:0] stall_cnt_q;

  // Saturates so a long run never wraps back to a small, misleading count.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt_q <= '0;
    end else if (stall && (stall_cnt_q != 32'hFFFF_FFFF)) begin
      stall_cnt_q <= stall_cnt_q + 32'd1;
    end
  end

  assign stallCnt = stall_cnt_q;
`endif

endmodule
